display_scan_mux: RTL

//  Upstream of the hex-to-7-segment decoder on the Basys3 4-digit display.

---
 rtl/display_scan_mux.sv | 52 +++++
 1 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: scans a double-buffered 16-bit value across four active-low anodes with dead-time blanking
module display_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  blank,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] last = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] dead = CW'(DEAD_CYCLES);
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow, staging;
  logic          wrap, boundary;
  always_comb begin
    wrap = cnt == last;
    boundary = wrap && idx == 2'd3;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
      staging <= '0;
      pending <= 1'b0;
      nibble <= '0;
      an <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 1'b1;
      nibble <= shadow[{idx, 2'b00} +: 4];
      an <= (cnt < dead || blank[idx]) ? 4'b1111 : ~(4'b0001 << idx);
      if (load) staging <= din;
      if (boundary) begin
        if (pending || load) shadow <= load ? din : staging;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
      frame_done <= boundary;
    end
  end
endmodule
